// File: rtl/pu_riscv_membuf_credit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pu_riscv_membuf_credit_if
//  Purpose  : Handshake bundle around the CPU-to-memory request buffer.
//             Carries the CPU request channel (req_i/d_i/rdy_o) and the
//             memory channel (req_o/q_o/ack_i/rsp_i/rsp_o). Signal suffixes
//             are written from the buffer's point of view.
//  Modports : slave  - the request buffer itself
//             master - the environment (request source plus memory side)
//  Revision : 1.0  initial release
// ============================================================================
interface pu_riscv_membuf_credit_if #(
    parameter int DBITS = 64
);
    // CPU request channel
    logic             req_i;
    logic [DBITS-1:0] d_i;
    logic             rdy_o;
    // Memory request / response channel
    logic             req_o;
    logic [DBITS-1:0] q_o;
    logic             ack_i;
    logic             rsp_i;
    logic             rsp_o;

    modport slave (
        input  req_i,
        input  d_i,
        output rdy_o,
        output req_o,
        output q_o,
        input  ack_i,
        input  rsp_i,
        output rsp_o
    );

    modport master (
        output req_i,
        output d_i,
        input  rdy_o,
        input  req_o,
        input  q_o,
        output ack_i,
        output rsp_i,
        input  rsp_o
    );
endinterface
`default_nettype wire

// File: rtl/pu_riscv_ram_queue.sv
`default_nettype none
// ============================================================================
//  Module   : pu_riscv_ram_queue
//  Purpose  : First-word fall-through FIFO, DEPTH entries of DBITS bits.
//             The head entry is always visible on q_o while not empty.
//  Ports    : clk_i, rst_ni  - clock, asynchronous active-low reset
//             clr_i          - synchronous flush (empties the queue)
//             ena_i          - write/read enable; contents held when low
//             we_i, d_i      - push request and data
//             re_i           - pop request (head leaves at the edge)
//             q_o            - head entry
//             empty_o,full_o - occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module pu_riscv_ram_queue #(
    parameter int DEPTH = 2,
    parameter int DBITS = 64
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             clr_i,
    input  wire logic             ena_i,
    input  wire logic             we_i,
    input  wire logic [DBITS-1:0] d_i,
    input  wire logic             re_i,
    output logic      [DBITS-1:0] q_o,
    output logic                  empty_o,
    output logic                  full_o
);
    // A one-entry queue still needs a 1-bit pointer to stay legal.
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(DEPTH - 1);

    logic [DBITS-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_cnt;

    logic w_we;
    logic w_re;

    // Overflow/underflow protection lives here so callers cannot corrupt
    // the occupancy count with a stray strobe.
    assign w_we = ena_i & ~clr_i & we_i & ~full_o;
    assign w_re = ena_i & ~clr_i & re_i & ~empty_o;

    assign empty_o = (r_cnt == '0);
    assign full_o  = (r_cnt == c_CW'(DEPTH));
    assign q_o     = r_mem[r_rptr];

    // Storage array carries no reset; occupancy is tracked separately.
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[r_wptr] <= d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (clr_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_we) begin
                r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + c_AW'(1);
            end
            if (w_re) begin
                r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + c_AW'(1);
            end
            r_cnt <= r_cnt + c_CW'(w_we) - c_CW'(w_re);
        end
    end
endmodule
`default_nettype wire

// File: rtl/pu_riscv_membuf_credit.sv
`default_nettype none
// ============================================================================
//  Module   : pu_riscv_membuf_credit
//  Purpose  : CPU-to-memory request buffer with same-cycle bypass, an
//             outstanding-credit limit and flush-safe response filtering.
//  Ports    : clk_i, rst_ni   - clock, asynchronous active-low reset
//             clr_i           - flush queued requests, kill in-flight ones
//             ena_i           - issue/accept enable (stall when low)
//             bus (slave)     - req_i/d_i/rdy_o CPU side,
//                               req_o/q_o/ack_i/rsp_i/rsp_o memory side
//             pending_o       - outstanding (issued, unanswered) count
//             empty_o,full_o  - queue occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module pu_riscv_membuf_credit #(
    parameter int DEPTH     = 2,
    parameter int DBITS     = 64,
    parameter int MAX_OUTST = 2
) (
    input  wire logic                               clk_i,
    input  wire logic                               rst_ni,
    input  wire logic                               clr_i,
    input  wire logic                               ena_i,
    pu_riscv_membuf_credit_if.slave                 bus,
    output logic [$clog2(MAX_OUTST+1)-1:0]          pending_o,
    output logic                                    empty_o,
    output logic                                    full_o
);
    localparam int c_OW = $clog2(MAX_OUTST + 1);
    localparam logic [c_OW-1:0] c_MAX = c_OW'(MAX_OUTST);

    logic [c_OW-1:0]  r_outst;
    logic [c_OW-1:0]  r_kill;

    logic [DBITS-1:0] w_head;
    logic             w_issue;
    logic             w_rsp_ok;
    logic             w_we;
    logic             w_re;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign bus.rdy_o = ena_i & ~clr_i & ~full_o;
    assign bus.req_o = ena_i & ~clr_i & (r_outst != c_MAX) & (~empty_o | bus.req_i);
    // Empty queue: the incoming request is presented directly (bypass).
    assign bus.q_o   = empty_o ? bus.d_i : w_head;

    assign w_issue = bus.req_o & bus.ack_i;
    // A request issued straight from d_i is never stored.
    assign w_we    = bus.req_i & bus.rdy_o & ~(empty_o & w_issue);
    assign w_re    = w_issue & ~empty_o;

    pu_riscv_ram_queue #(
        .DEPTH (DEPTH),
        .DBITS (DBITS)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .ena_i   (ena_i),
        .we_i    (w_we),
        .d_i     (bus.d_i),
        .re_i    (w_re),
        .q_o     (w_head),
        .empty_o (empty_o),
        .full_o  (full_o)
    );

    // ------------------------------------------------------------------
    // Response side: runs regardless of ena_i/clr_i since memory
    // responses cannot be stalled.
    // ------------------------------------------------------------------
    // A response with nothing outstanding (e.g. arriving after a reset)
    // is ignored entirely.
    assign w_rsp_ok  = bus.rsp_i & (r_outst != '0);
    assign bus.rsp_o = w_rsp_ok & (r_kill == '0);
    assign pending_o = r_outst;

    // Credit returns only at the edge, so a response never unblocks
    // req_o in its own cycle. req_o already excludes the full-credit
    // case, so the increment cannot overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outst <= '0;
        end else begin
            r_outst <= r_outst + c_OW'(w_issue) - c_OW'(w_rsp_ok);
        end
    end

    // Kill count tracks how many of the outstanding responses belong to
    // requests issued before the last flush. Killed requests are the
    // oldest ones, so they are exactly the next r_kill responses. A
    // response coinciding with the flush consumes one credit first; it
    // is forwarded or swallowed according to the pre-flush kill count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_kill <= '0;
        end else if (clr_i) begin
            r_kill <= r_outst - c_OW'(w_rsp_ok);
        end else if (w_rsp_ok && (r_kill != '0)) begin
            r_kill <= r_kill - c_OW'(1);
        end
    end
endmodule
`default_nettype wire
